serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single borrow stage (full-subtractor cell) so the area stays flat as WIDTH grows.
- Sits alongside the arithmetic blocks as the inverse operation to the adder datapath.
- Controlled by a start/busy/done handshake toward the issuing controller.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  minuend, unsigned; captured on an accepted start.
- b  input  WIDTH  subtrahend, unsigned; captured on an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse when diff/borrow_out update.
- diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next completion.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.

Behaviour:
- Reset (synchronous, active-high) values:
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal borrow=0, bit counter=0, state=IDLE.
- Reset has priority over every other input, including mid-operation: the operation in flight is abandoned, no done pulse is issued, and diff/borrow_out return to 0.
- States:
  - IDLE: busy=0, done=0. start=1 → capture a, b into shift registers, clear internal borrow and counter, go to RUN.
  - RUN: busy=1. Each cycle:
    - Process bit i: d_i = a_i ^ b_i ^ bw; bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw).
    - Shift d_i into the result shift register; shift the operand registers right; increment the counter.
    - After bit WIDTH-1 is processed → go to DONE.
  - DONE: the edge that processes bit WIDTH-1 also loads diff and borrow_out (= final bw). During the DONE cycle done=1 and busy=0.
    - start=1 in DONE → accepted exactly as in IDLE (back-to-back operation), go to RUN.
    - Otherwise go to IDLE.
- Latency: start sampled high at edge k.
  - busy=1 from edge k through edge k+WIDTH-1.
  - done=1, with new diff/borrow_out valid, in the cycle following edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- start while busy=1 is ignored. Operands are not re-captured, and the operation in flight is unaffected.
- a and b may change freely after the capture edge; the result depends only on the captured values.
- diff and borrow_out never change except on the completion edge or on reset. Partial results are never visible.
- done is high for exactly one cycle per accepted start; it is never asserted while busy=1.
- Wrap-around: the result is modulo 2^WIDTH. Example (WIDTH=4): 0 - 1 → diff=4'hF, borrow_out=1.
- Counter width is clog2(WIDTH)+1 bits; there is no counter overflow for any legal WIDTH.

Test Plan:
- WIDTH=4, reset 2 cycles, then a=5, b=3, start pulse 1 cycle → busy high 4 cycles; done pulses 4 cycles after the start edge; diff=2, borrow_out=0; outputs held afterward.
- a=3, b=5 → diff=4'hE, borrow_out=1. Also a=0, b=1 → diff=4'hF, borrow_out=1.
- Edge operands:
  - a=15, b=15 → diff=0, borrow_out=0.
  - a=15, b=0 → diff=15, borrow_out=0.
  - a=0, b=0 → diff=0, borrow_out=0.
- a=9, b=4 started; during RUN pulse start with a=1, b=2 and change a/b every cycle → only 9-4=5 is produced; exactly one done pulse.
- Start a=12, b=7; assert reset on the 2nd RUN cycle → next cycle busy=0, done=0, diff=0, borrow_out=0; no done ever follows. A new start after reset works (6-6 → 0).
- start held high with a=8, b=1, then a=2, b=3 presented in the DONE cycle → first done gives diff=7, borrow_out=0; the second op is accepted in the DONE cycle; second done WIDTH+1 cycles later gives diff=4'hF, borrow_out=1.
- Random: WIDTH=8, 1000 random a/b pairs compared against a behavioural model (diff and borrow_out).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Handshake and data bundle between an issuing controller and the
//   bit-serial subtractor.
//   start, a, b      : controller -> subtractor (request and operands)
//   busy, done       : subtractor -> controller (progress / completion pulse)
//   diff, borrow_out : subtractor -> controller (held result)
//   master modport: the controller side; slave modport: the subtractor side.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH, processed LSB
//   first through a single full-subtractor cell, one bit per clock.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any operation in flight
//   bus   : serial_subtractor_if slave (start/a/b in, busy/done/diff/borrow_out out)
//   WIDTH must match the WIDTH of the connected interface (legal 2..32).
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one operand bit per cycle through the borrow cell; start ignored
//   DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bw;
    logic [CNT_W-1:0] cnt;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic bw_nx;
    logic last_bit;
    logic accept;

    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        d_bit    = a_bit ^ b_bit ^ bw;
        bw_nx    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        // start is only honoured outside RUN, so a request mid-operation is dropped
        accept   = (state != RUN) && bus.start;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_bit)  state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bw       <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sr <= bus.a;
                b_sr <= bus.b;
                bw   <= 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                // result enters at the MSB so after WIDTH shifts bit i sits at position i
                res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                bw     <= bw_nx;
                cnt    <= cnt + 1'b1;
                if (last_bit) begin
                    diff_q   <= {d_bit, res_sr[WIDTH-1:1]};
                    borrow_q <= bw_nx;
                end
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule
